// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - in-order ALU command issue stage with FIFO, issue register and result tag tracking
module alu_issue #(
  parameter int DATA_WIDTH  = 32,
  parameter int CTRL_WIDTH  = 5,
  parameter int SHAMT_WIDTH = 5,
  parameter int DEPTH       = 4,
  parameter int TAG_WIDTH   = 4,
  parameter int DELAY       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_opA,
  input  logic [DATA_WIDTH-1:0]   in_opB,
  input  logic [CTRL_WIDTH-1:0]   in_ctrl,
  input  logic [SHAMT_WIDTH-1:0]  in_shamt,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  input  logic                    issue_hold,
  output logic [2*DATA_WIDTH-1:0] alu_dataIn,
  output logic [CTRL_WIDTH-1:0]   alu_ctrl,
  output logic [SHAMT_WIDTH-1:0]  alu_shamt,
  output logic                    alu_en_n,
  output logic                    out_valid,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    err_illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2*DATA_WIDTH + CTRL_WIDTH + SHAMT_WIDTH + TAG_WIDTH;
  localparam logic [CW-1:0]         FULL_CNT  = CW'(DEPTH);
  localparam logic [CTRL_WIDTH-1:0] IDLE_CTRL = CTRL_WIDTH'(5'h1F);
  localparam logic [CTRL_WIDTH-1:0] MAX_CTRL  = CTRL_WIDTH'(5'h11);

  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic                    issue_valid_q, issue_valid_d;
  logic [2*DATA_WIDTH-1:0] issue_data_q, issue_data_d;
  logic [CTRL_WIDTH-1:0]   issue_ctrl_q, issue_ctrl_d;
  logic [SHAMT_WIDTH-1:0]  issue_shamt_q, issue_shamt_d;
  logic [TAG_WIDTH-1:0]    issue_tag_q, issue_tag_d;
  logic                    err_q, err_d;

  logic                    clear, push, pop, head_illegal;
  logic [2*DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0]   head_ctrl;
  logic [SHAMT_WIDTH-1:0]  head_shamt;
  logic [TAG_WIDTH-1:0]    head_tag;

  assign clear    = !rst || flush;
  assign in_ready = rst && (count_q < FULL_CNT);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (count_q != '0) && !issue_hold && !flush;

  assign {head_data, head_ctrl, head_shamt, head_tag} = mem_q[rd_ptr_q];
  assign head_illegal = head_ctrl > MAX_CTRL;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (!push && pop) count_d = count_q - CW'(1);

    // Illegal opcodes are consumed but leave the ALU idle for that slot.
    issue_valid_d = pop && !head_illegal;
    err_d         = pop && head_illegal;
    issue_data_d  = '0;
    issue_ctrl_d  = IDLE_CTRL;
    issue_shamt_d = '0;
    issue_tag_d   = '0;
    if (issue_valid_d) begin
      issue_data_d  = head_data;
      issue_ctrl_d  = head_ctrl;
      issue_shamt_d = head_shamt;
      issue_tag_d   = head_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_opA, in_opB, in_ctrl, in_shamt, in_tag};
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_data_q  <= '0;
      issue_ctrl_q  <= IDLE_CTRL;
      issue_shamt_q <= '0;
      issue_tag_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_data_q  <= issue_data_d;
      issue_ctrl_q  <= issue_ctrl_d;
      issue_shamt_q <= issue_shamt_d;
      issue_tag_q   <= issue_tag_d;
      err_q         <= err_d;
    end
  end

  assign alu_dataIn  = issue_data_q;
  assign alu_ctrl    = issue_ctrl_q;
  assign alu_shamt   = issue_shamt_q;
  assign alu_en_n    = !issue_valid_q;
  assign err_illegal = err_q;

  // Tag pipeline mirrors the ALU's result latency.
  generate
    if (DELAY == 0) begin : g_nodelay
      assign out_valid = issue_valid_q;
      assign out_tag   = issue_tag_q;
    end else begin : g_delay
      logic                 vpipe_q [DELAY];
      logic [TAG_WIDTH-1:0] tpipe_q [DELAY];

      always_ff @(posedge clk) begin
        if (clear) begin
          for (int i = 0; i < DELAY; i++) begin
            vpipe_q[i] <= 1'b0;
            tpipe_q[i] <= '0;
          end
        end else begin
          vpipe_q[0] <= issue_valid_q;
          tpipe_q[0] <= issue_tag_q;
          for (int i = 1; i < DELAY; i++) begin
            vpipe_q[i] <= vpipe_q[i-1];
            tpipe_q[i] <= tpipe_q[i-1];
          end
        end
      end

      assign out_valid = vpipe_q[DELAY-1];
      assign out_tag   = tpipe_q[DELAY-1];
    end
  endgenerate
endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue with a queue-based reference model
module tb_alu_issue;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int DELAY = 2;

  logic          clk, rst, flush, in_valid, in_ready, issue_hold;
  logic [DW-1:0] in_opA, in_opB;
  logic [4:0]    in_ctrl, in_shamt, alu_ctrl, alu_shamt;
  logic [3:0]    in_tag, out_tag;
  logic [2*DW-1:0] alu_dataIn;
  logic          alu_en_n, out_valid, err_illegal;

  alu_issue #(.DATA_WIDTH(DW), .CTRL_WIDTH(5), .SHAMT_WIDTH(5), .DEPTH(DEPTH),
              .TAG_WIDTH(4), .DELAY(DELAY)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opA(in_opA), .in_opB(in_opB), .in_ctrl(in_ctrl), .in_shamt(in_shamt),
    .in_tag(in_tag), .issue_hold(issue_hold), .alu_dataIn(alu_dataIn),
    .alu_ctrl(alu_ctrl), .alu_shamt(alu_shamt), .alu_en_n(alu_en_n),
    .out_valid(out_valid), .out_tag(out_tag), .err_illegal(err_illegal));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a, b;
    logic [4:0]    c, s;
    logic [3:0]    t;
  } cmd_t;

  int total = 0, bad = 0, cyc = 0;
  bit started = 0;

  cmd_t fq[$];
  bit   m_iv = 0, m_err = 0;
  cmd_t m_cmd;
  bit   pv[$];
  logic [3:0] pt[$];

  logic [3:0] tag_log[$];
  int         tag_cyc[$];
  logic [4:0] ctrl_log[$];
  int         ctrl_cyc[$];
  int         err_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, latency as a DELAY-long queue of results.
  always @(posedge clk) begin
    bit   do_push, do_pop;
    cmd_t h, n;
    cyc++;
    if (!rst || flush) begin
      fq.delete();
      m_iv = 0; m_err = 0;
      pv.delete(); pt.delete();
      for (int i = 0; i < DELAY; i++) begin pv.push_back(0); pt.push_back(4'd0); end
    end else begin
      do_push = in_valid && (fq.size() < DEPTH);
      do_pop  = (fq.size() > 0) && !issue_hold;
      pv.push_back(m_iv); pt.push_back(m_iv ? m_cmd.t : 4'd0);
      void'(pv.pop_front()); void'(pt.pop_front());
      m_iv = 0; m_err = 0;
      if (do_pop) begin
        h = fq.pop_front();
        if (h.c > 5'h11) m_err = 1;
        else begin m_iv = 1; m_cmd = h; end
      end
      if (do_push) begin
        n.a = in_opA; n.b = in_opB; n.c = in_ctrl; n.s = in_shamt; n.t = in_tag;
        fq.push_back(n);
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, rst && (fq.size() < DEPTH)});
      chk("alu_en_n", {63'd0, alu_en_n}, {63'd0, !m_iv});
      chk("alu_ctrl", {59'd0, alu_ctrl}, {59'd0, m_iv ? m_cmd.c : 5'h1F});
      chk("alu_shamt", {59'd0, alu_shamt}, {59'd0, m_iv ? m_cmd.s : 5'h0});
      chk("alu_dataIn", alu_dataIn, m_iv ? {m_cmd.a, m_cmd.b} : 64'd0);
      chk("err_illegal", {63'd0, err_illegal}, {63'd0, m_err});
      chk("out_valid", {63'd0, out_valid}, {63'd0, pv[0]});
      if (pv[0]) chk("out_tag", {60'd0, out_tag}, {60'd0, pt[0]});
      if (out_valid) begin tag_log.push_back(out_tag); tag_cyc.push_back(cyc); end
      if (!alu_en_n) begin ctrl_log.push_back(alu_ctrl); ctrl_cyc.push_back(cyc); end
      if (err_illegal) err_cnt++;
    end
  end

  task automatic clear_logs();
    tag_log.delete(); tag_cyc.delete(); ctrl_log.delete(); ctrl_cyc.delete();
    err_cnt = 0;
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [4:0] c,
                          input logic [3:0] t, output bit acc);
    in_valid = 1; in_opA = a; in_opB = b; in_ctrl = c; in_shamt = 5'd0; in_tag = t;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit acc;
    int acc_cnt;
    rst = 0; flush = 0; issue_hold = 0;
    in_valid = 1; in_opA = 32'd9; in_opB = 32'd9; in_ctrl = 5'h2; in_shamt = 5'd0; in_tag = 4'd9;

    // Reset held with in_valid high
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_alu_ctrl", {59'd0, alu_ctrl}, 64'h1F);
      chk("rst_alu_en_n", {63'd0, alu_en_n}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    rst = 1; in_valid = 0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    clear_logs();
    push_cmd(32'd5, 32'd3, 5'h5, 4'd1, acc);
    in_valid = 0;
    @(posedge clk); #1;
    chk("first_dataIn", alu_dataIn, {32'd5, 32'd3});
    chk("first_ctrl", {59'd0, alu_ctrl}, 64'd5);
    idle_cycles(4);
    chk("first_tag_cnt", tag_log.size(), 64'd1);
    chk("first_tag", {60'd0, tag_log[0]}, 64'd1);

    // Back-to-back tags 0..7
    clear_logs(); acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      push_cmd(i * 3, i + 1, 5'h0, 4'(i), acc);
      acc_cnt += int'(acc);
    end
    idle_cycles(6);
    chk("b2b_accepts", acc_cnt, 64'd8);
    chk("b2b_tag_cnt", tag_log.size(), 64'd8);
    for (int i = 0; i < 8; i++) chk("b2b_tag", {60'd0, tag_log[i]}, i);
    for (int i = 1; i < 8; i++) chk("b2b_gap", tag_cyc[i] - tag_cyc[i-1], 64'd1);

    // Fill under hold, three rounds to cross pointer wrap
    for (int r = 0; r < 3; r++) begin
      clear_logs(); acc_cnt = 0;
      issue_hold = 1;
      for (int i = 0; i < 5; i++) begin
        push_cmd(32'd100 + i, 32'd7, 5'h1, 4'(4*r + i), acc);
        if (i < 4) acc_cnt += int'(acc);
        else chk("full_5th_ready", {63'd0, acc}, 64'd0);
      end
      chk("full_accepts", acc_cnt, 64'd4);
      in_valid = 0; issue_hold = 0;
      idle_cycles(8);
      chk("full_tag_cnt", tag_log.size(), 64'd4);
      for (int i = 0; i < 4; i++) chk("full_tag", {60'd0, tag_log[i]}, 4*r + i);
    end

    // Illegal opcode between tags 1 and 3
    clear_logs();
    push_cmd(32'd1, 32'd1, 5'h0, 4'd1, acc);
    push_cmd(32'd2, 32'd2, 5'h12, 4'd2, acc);
    push_cmd(32'd3, 32'd3, 5'h0, 4'd3, acc);
    idle_cycles(6);
    chk("ill_err_cnt", err_cnt, 64'd1);
    chk("ill_tag_cnt", tag_log.size(), 64'd2);
    chk("ill_tag0", {60'd0, tag_log[0]}, 64'd1);
    chk("ill_tag1", {60'd0, tag_log[1]}, 64'd3);

    // Flush with 3 queued and 1 in the issue register
    clear_logs();
    issue_hold = 1;
    for (int i = 0; i < 4; i++) push_cmd(32'd50, 32'd1, 5'h0, 4'(4 + i), acc);
    in_valid = 0; issue_hold = 0;
    @(posedge clk); #1;
    flush = 1; issue_hold = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    issue_hold = 0;
    idle_cycles(6);
    chk("flush_no_out", tag_log.size(), 64'd0);

    // mult / mfhi / mflo ordering
    clear_logs();
    push_cmd(32'd7, 32'd6, 5'h6, 4'd10, acc);
    push_cmd(32'd0, 32'd0, 5'hB, 4'd11, acc);
    push_cmd(32'd0, 32'd0, 5'hC, 4'd12, acc);
    idle_cycles(6);
    chk("hilo_cnt", ctrl_log.size(), 64'd3);
    chk("hilo_c0", {59'd0, ctrl_log[0]}, 64'h6);
    chk("hilo_c1", {59'd0, ctrl_log[1]}, 64'hB);
    chk("hilo_c2", {59'd0, ctrl_log[2]}, 64'hC);
    chk("hilo_gap1", ctrl_cyc[1] - ctrl_cyc[0], 64'd1);
    chk("hilo_gap2", ctrl_cyc[2] - ctrl_cyc[1], 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
